// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
//  Types shared by the cache/RAM arbitration path.
//  ramstate_t  : RAM handshake state as driven by the RAM model
//                (FREE=0, BUSY=1, ACCESS=2, ERROR=3).
//  arb_state_t : arbiter FSM states (IDLE, IGNT, DGNT).
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//  Shares the single RAM port between the icache fill path and the dcache
//  fill/writeback/flush path. One requester owns the RAM at a time and keeps
//  it until that word access completes (ramstate == ACCESS). dcache has
//  priority, but after STARVE_MAX consecutive dcache grants taken while the
//  icache was waiting, the icache wins the next arbitration.
//
//  Ports
//   CLK, RST              clock (rising edge), asynchronous active-high reset
//   iREN, iaddr           icache read request and word address
//   iload, iwait          icache read data, stall (low only in completion cycle)
//   dREN, dWEN            dcache read / write request (write wins)
//   daddr, dstore         dcache word address and write data
//   dload, dwait          dcache read data, stall (low only in completion cycle)
//   ramREN, ramWEN        RAM read / write enables
//   ramaddr, ramstore     RAM address and write data
//   ramload, ramstate     RAM read data and handshake state (ramstate_t)
//
//  All outputs are combinational from the FSM state and the current inputs.
module cache_mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4   // 1..15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  localparam logic [3:0] STREAK_LIM = 4'(STARVE_MAX);

  arb_state_t state_reg, state_next;
  logic [3:0] streak_reg, streak_next;
  ramstate_t  ram_st;
  logic       dreq;
  logic       ram_done;
  logic       starve;

  assign ram_st   = ramstate_t'(ramstate);
  assign dreq     = dREN | dWEN;
  assign ram_done = (ram_st == ACCESS);
  // icache has waited through enough dcache grants and must win now.
  assign starve   = iREN && (streak_reg == STREAK_LIM);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg  <= IDLE;
      streak_reg <= 4'd0;
    end else begin
      state_reg  <= state_next;
      streak_reg <= streak_next;
    end
  end

  // Every grant returns to IDLE, either on completion or when the owner
  // drops its request, so a request about to be dropped is never re-granted.
  always_comb begin
    state_next  = state_reg;
    streak_next = streak_reg;
    case (state_reg)
      IDLE: begin
        if (dreq && !starve) begin
          state_next = DGNT;
          if (iREN) begin
            streak_next = (streak_reg == STREAK_LIM) ? streak_reg : streak_reg + 4'd1;
          end else begin
            streak_next = 4'd0;
          end
        end else if (iREN) begin
          state_next  = IGNT;
          streak_next = 4'd0;
        end
      end
      IGNT: begin
        if (!iREN || ram_done) state_next = IDLE;
      end
      DGNT: begin
        if (!dreq || ram_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // RAM side and cache side outputs. ERROR is treated like BUSY: the owner
  // simply keeps waiting. Enables are gated by the owner's live request so
  // a dropped request releases the RAM in the same cycle.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'd0;
    ramstore = 32'd0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = 32'd0;
    dload    = 32'd0;
    case (state_reg)
      IGNT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        if (iREN && ram_done) begin
          iwait = 1'b0;
          iload = ramload;
        end
      end
      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (dreq && ram_done) begin
          dwait = 1'b0;
          dload = ramload;
        end
      end
      default: ;
    endcase
  end

endmodule
